// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: register addresses and edge-type codes,
// plus the helper that decides whether a debounced transition is an edge event.
package pio_pkg;

   // Register map (word addresses on the Avalon-MM slave)
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // Edge-type selection for edgecapture
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // True when a debounced bit moving to new_level counts as an edge event.
   function automatic logic edge_qualifies(input int edge_type, input logic new_level);
      case (edge_type)
         EDGE_RISE: return new_level;
         EDGE_FALL: return ~new_level;
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter and debounced level.
// edge_evt is high during the cycle whose closing clk edge updates deb, so a
// register sampling it captures the event on the same edge deb changes.
module pio_debounce_bit
   import pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int EDGE_TYPE       = EDGE_ANY
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic deb,
   output logic edge_evt
);

   logic sync_meta;
   logic sync;
   logic update;

   // Bring the asynchronous pin into the clk domain.
   // NOTE: every flop here, sync_meta included, resets asynchronously so a
   // reset mid-count leaves no stale value that could later fire an event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         // NOTE: non-blocking so sync sees the old sync_meta, giving two stages.
         sync_meta <= din;
         sync      <= sync_meta;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         // Without debounce, deb simply follows sync one edge later.
         assign update = (sync != deb);
      end else begin : g_count
         localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] cnt;

         // Count consecutive cycles sync differs from deb; any agreement restarts.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt <= '0;
            end else if ((sync == deb) || (cnt == CNT_LAST)) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         assign update = (sync != deb) && (cnt == CNT_LAST);
      end
   endgenerate

   // Debounced level takes the synchronized value once it has been stable long enough.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb <= 1'b0;
      end else if (update) begin
         deb <= sync;
      end
   end

   assign edge_evt = update && edge_qualifies(EDGE_TYPE, sync);

endmodule

// File: rtl/pio_button_in.sv
// Avalon-MM input PIO: per-bit synchronize/debounce, edge capture with
// write-1-to-clear, masked level interrupt, zero-wait-state read mux.
module pio_button_in
   import pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int EDGE_TYPE       = EDGE_ANY
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] edge_clr;
   logic             wr_en;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_TYPE       (EDGE_TYPE)
         ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .din      (in_port[i]),
            .deb      (deb[i]),
            .edge_evt (edge_evt[i])
         );
      end
   endgenerate

   assign wr_en    = chipselect && !write_n;
   assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? writedata : '0;

   // Interrupt mask register, plain read/write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask <= '0;
      end else if (wr_en && (address == ADDR_MASK)) begin
         irqmask <= writedata;
      end
   end

   // Edge capture: clear is applied first so a same-edge event still sets the bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecapture <= '0;
      end else begin
         edgecapture <= (edgecapture & ~edge_clr) | edge_evt;
      end
   end

   // Read mux, combinational; unselected or reserved addresses read zero.
   always_comb begin
      // NOTE: default first so every path assigns readdata and no latch is inferred.
      readdata = '0;
      if (chipselect) begin
         case (address)
            ADDR_DATA: readdata = deb;
            ADDR_RSVD: readdata = '0;
            ADDR_MASK: readdata = irqmask;
            ADDR_EDGE: readdata = edgecapture;
            default:   readdata = '0;
         endcase
      end
   end

   assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_button_in.sv
// Directed bench for pio_button_in with WIDTH=4, DEBOUNCE_CYCLES=4.
// One instance captures any edge, a second one only falling edges; both share
// the bus and inputs. Inputs are driven on the falling clk edge.
module tb_pio_button_in;

   localparam int W  = 4;
   localparam int DC = 4;

   logic         clk;
   logic         reset_n;
   logic [1:0]   address;
   logic         chipselect;
   logic         write_n;
   logic [W-1:0] writedata;
   logic [W-1:0] in_port;
   logic [W-1:0] readdata_a;
   logic         irq_a;
   logic [W-1:0] readdata_f;
   logic         irq_f;

   int n_vec = 0;
   int n_bad = 0;

   pio_button_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata_a),
      .in_port    (in_port),
      .irq        (irq_a)
   );

   pio_button_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) dut_fall (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata_f),
      .in_port    (in_port),
      .irq        (irq_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         do_wr;
      logic [1:0]   wr_addr;
      logic [W-1:0] wdata;
      logic [W-1:0] in_val;
      int           wait_cyc;
      logic [1:0]   rd_addr;
      logic [W-1:0] exp_rd;
      logic         exp_irq;
      string        name;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance n clk rising edges, ending just after a falling edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle bus write; it commits on the next rising edge.
   task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Present a read; readdata is combinational so it is valid after a short settle.
   task automatic bus_read(input logic [1:0] a);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
   endtask

   task automatic add_row(input logic do_wr, input logic [1:0] wa, input logic [W-1:0] wd,
                          input logic [W-1:0] inv, input int wc, input logic [1:0] ra,
                          input logic [W-1:0] er, input logic ei, input string nm);
      vec_t v;
      v.do_wr = do_wr; v.wr_addr = wa; v.wdata = wd; v.in_val = inv; v.wait_cyc = wc;
      v.rd_addr = ra; v.exp_rd = er; v.exp_irq = ei; v.name = nm;
      tbl.push_back(v);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         in_port = tbl[i].in_val;
         if (tbl[i].do_wr) bus_write(tbl[i].wr_addr, tbl[i].wdata);
         tick(tbl[i].wait_cyc);
         bus_read(tbl[i].rd_addr);
         check({tbl[i].name, "_rd"}, 32'(readdata_a), 32'(tbl[i].exp_rd));
         check({tbl[i].name, "_irq"}, 32'(irq_a), 32'(tbl[i].exp_irq));
         chipselect = 1'b0;
      end
   endtask

   initial begin
      // Rows 0-3: register defaults after reset.
      add_row(0, 0, 0, 4'b0000, 0, 2'd0, 4'b0000, 0, "rst_data");
      add_row(0, 0, 0, 4'b0000, 0, 2'd1, 4'b0000, 0, "rst_rsvd");
      add_row(0, 0, 0, 4'b0000, 0, 2'd2, 4'b0000, 0, "rst_mask");
      add_row(0, 0, 0, 4'b0000, 0, 2'd3, 4'b0000, 0, "rst_ecap");
      // Rows 4-12: glitch rejection, hold, W1C, mask, reserved, read-only data.
      add_row(0, 0, 0, 4'b0011, 3, 2'd0, 4'b0001, 1, "glitch_hi");
      add_row(0, 0, 0, 4'b0001, 8, 2'd0, 4'b0001, 1, "glitch_data");
      add_row(0, 0, 0, 4'b0001, 0, 2'd3, 4'b0001, 1, "glitch_ecap");
      add_row(0, 0, 0, 4'b0011, 8, 2'd0, 4'b0011, 1, "hold_data");
      add_row(0, 0, 0, 4'b0011, 0, 2'd3, 4'b0011, 1, "hold_ecap");
      add_row(1, 2'd3, 4'b0001, 4'b0011, 0, 2'd3, 4'b0010, 0, "w1c_ecap");
      add_row(1, 2'd2, 4'b0010, 4'b0011, 0, 2'd2, 4'b0010, 1, "mask_irq");
      add_row(1, 2'd1, 4'b1111, 4'b0011, 0, 2'd1, 4'b0000, 1, "rsvd_wr");
      add_row(1, 2'd0, 4'b1111, 4'b0011, 0, 2'd0, 4'b0011, 1, "data_ro");

      address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = '0;
      reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(1);

      run_rows(0, 3);

      // Rising bit 0 with mask set: visible exactly DC+2 edges after the change.
      bus_write(2'd2, 4'b0001);
      in_port = 4'b0001;
      tick(DC + 1);
      bus_read(2'd0);
      check("rise_early_data", 32'(readdata_a), 32'h0);
      check("rise_early_irq", 32'(irq_a), 32'h0);
      tick(1);
      bus_read(2'd0);
      check("rise_data", 32'(readdata_a), 32'h1);
      check("rise_irq", 32'(irq_a), 32'h1);
      bus_read(2'd3);
      check("rise_ecap", 32'(readdata_a), 32'h1);
      check("fall_dut_rise_ecap", 32'(readdata_f), 32'h0);
      check("fall_dut_rise_irq", 32'(irq_f), 32'h0);
      chipselect = 1'b0;
      address    = 2'd0;
      #1;
      check("cs_low_rd", 32'(readdata_a), 32'h0);

      run_rows(4, 12);

      // Collision: clear of bit 2 lands on the same edge bit 2 debounces.
      bus_write(2'd3, 4'b1111);
      in_port = 4'b0111;
      tick(DC + 1);
      bus_write(2'd3, 4'b0100);
      bus_read(2'd3);
      check("collide_ecap", 32'(readdata_a), 32'h4);
      check("collide_irq", 32'(irq_a), 32'h0);
      bus_read(2'd0);
      check("collide_data", 32'(readdata_a), 32'h7);
      bus_write(2'd3, 4'b0100);
      bus_read(2'd3);
      check("clr_bit2", 32'(readdata_a), 32'h0);

      // Falling bit 2: captured by both the any-edge and the falling-edge instance.
      in_port = 4'b0011;
      tick(DC + 4);
      bus_read(2'd3);
      check("fall_any_ecap", 32'(readdata_a), 32'h4);
      check("fall_dut_ecap", 32'(readdata_f), 32'h4);
      bus_write(2'd2, 4'b0100);
      bus_read(2'd2);
      check("fall_any_irq", 32'(irq_a), 32'h1);
      check("fall_dut_irq", 32'(irq_f), 32'h1);
      chipselect = 1'b0;

      // Reset in the middle of a debounce count on bit 2.
      in_port = 4'b0111;
      tick(4);
      reset_n = 1'b0;
      bus_read(2'd0);
      check("rst_mid_data", 32'(readdata_a), 32'h0);
      check("rst_mid_irq", 32'(irq_a), 32'h0);
      tick(1);
      reset_n = 1'b1;
      tick(DC + 1);
      bus_read(2'd0);
      check("post_rst_data_early", 32'(readdata_a), 32'h0);
      bus_read(2'd3);
      check("post_rst_ecap_early", 32'(readdata_a), 32'h0);
      tick(1);
      bus_read(2'd0);
      check("post_rst_data", 32'(readdata_a), 32'h7);
      bus_read(2'd3);
      check("post_rst_ecap", 32'(readdata_a), 32'h7);
      check("post_rst_irq", 32'(irq_a), 32'h0);
      check("post_rst_fall_ecap", 32'(readdata_f), 32'h0);
      chipselect = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
